// File: rtl/s10_sum_tree_plus_const_if.sv
// s10_sum_tree_plus_const_if: input and output valid/ready streams of the adder tree.
// master drives operands and out_ready; slave is the tree itself.
interface s10_sum_tree_plus_const_if #(
  parameter int DW    = 96,
  parameter int TAG_W = 4,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DW-1:0]           in_data;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [TAG_W-1:0]        out_tag;
  logic                    out_sat;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_sat
  );
endinterface

// File: rtl/s10_sum_tree_plus_const.sv
// s10_sum_tree_plus_const: pipelined signed adder tree, NUM operands plus CONST.
// Define S10_SUM_SAT_EN to clamp the final sum to SIZE+1 signed bits.
module s10_sum_tree_plus_const #(
  parameter  int SIZE  = 12,
  parameter  int NUM   = 8,
  parameter  int CONST = 1,
  parameter  int TAG_W = 4,
  localparam int LVL   = $clog2(NUM),
  localparam int OUT_W = SIZE + LVL + 1,
  localparam int NP    = 1 << LVL
) (
  input logic clk,
  input logic rst_n,
  s10_sum_tree_plus_const_if.slave io
);
  localparam logic signed [SIZE-1:0] CST = SIZE'(CONST);

  logic                    en;
  logic signed [SIZE-1:0]  op [NP];
  logic                    vld_q [1:LVL];
  logic [TAG_W-1:0]        tag_q [1:LVL];
  logic signed [OUT_W-1:0] fin_d;
  logic signed [OUT_W-1:0] dat_d;
  logic signed [OUT_W-1:0] dat_q;

  assign en          = !vld_q[LVL] || io.out_ready;
  assign io.in_ready = rst_n && en;

  for (genvar i = 0; i < NP; i++) begin : g_op
    if (i < NUM) begin : g_in
      assign op[i] = io.in_data[i*SIZE +: SIZE];
    end else begin : g_pad
      assign op[i] = '0;
    end
  end

  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    localparam int W = SIZE + k + 1;
    for (genvar j = 0; j < (NP >> k); j++) begin : g_node
      logic signed [W-1:0] s_d;
      if (k == 1 && j == 0) begin : g_csa
        // carry-save form folds CONST in without a third carry chain
        logic signed [SIZE-1:0] x;
        logic signed [SIZE-1:0] m;
        assign x   = op[0] ^ op[1] ^ CST;
        assign m   = (op[0] & op[1])
                   | (op[0] & CST)
                   | (op[1] & CST);
        assign s_d = W'(x) + (W'(m) <<< 1);
      end else if (k == 1) begin : g_leaf
        assign s_d = W'(op[2*j]) + W'(op[2*j+1]);
      end else begin : g_sum
        assign s_d = W'(g_lvl[k-1].g_node[2*j].g_reg.s_q)
                   + W'(g_lvl[k-1].g_node[2*j+1].g_reg.s_q);
      end
      if (k < LVL) begin : g_reg
        logic signed [W-1:0] s_q;
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            s_q <= '0;
          end else if (en) begin
            s_q <= s_d;
          end
        end
      end
    end
  end

  assign fin_d = g_lvl[LVL].g_node[0].s_d;

`ifdef S10_SUM_SAT_EN
  localparam logic signed [OUT_W-1:0] SMAX =
    OUT_W'((longint'(1) << SIZE) - 1);
  localparam logic signed [OUT_W-1:0] SMIN =
    OUT_W'(-(longint'(1) << SIZE));

  logic sat_d;
  logic sat_q;

  always_comb begin
    dat_d = fin_d;
    sat_d = 1'b0;
    if (fin_d > SMAX) begin
      dat_d = SMAX;
      sat_d = 1'b1;
    end else if (fin_d < SMIN) begin
      dat_d = SMIN;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (en) begin
      sat_q <= sat_d;
    end
  end

  assign io.out_sat = sat_q;
`else
  assign dat_d      = fin_d;
  assign io.out_sat = 1'b0;
`endif

  // bubbles advance like real beats; the tree never collapses them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= LVL; k++) begin
        vld_q[k] <= 1'b0;
        tag_q[k] <= '0;
      end
      dat_q <= '0;
    end else if (en) begin
      vld_q[1] <= io.in_valid;
      tag_q[1] <= io.in_tag;
      for (int k = 2; k <= LVL; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
      dat_q <= dat_d;
    end
  end

  assign io.out_valid = vld_q[LVL];
  assign io.out_tag   = tag_q[LVL];
  assign io.out_data  = dat_q;
endmodule

// File: tb/tb_s10_sum_tree_plus_const.sv
// tb_s10_sum_tree_plus_const: directed and random checks of three tree builds
// against an arithmetic reference (sum + CONST, optional clamp).
module tb_s10_sum_tree_plus_const;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  s10_sum_tree_plus_const_if #(.DW(32), .TAG_W(4), .OUT_W(11)) ia ();
  s10_sum_tree_plus_const_if #(.DW(96), .TAG_W(4), .OUT_W(16)) ib ();
  s10_sum_tree_plus_const_if #(.DW(24), .TAG_W(4), .OUT_W(11)) ic ();

  s10_sum_tree_plus_const #(
    .SIZE(8), .NUM(4), .CONST(1), .TAG_W(4)
  ) u_a (.clk(clk), .rst_n(rst_n), .io(ia));

  s10_sum_tree_plus_const #(
    .SIZE(12), .NUM(8), .CONST(-5), .TAG_W(4)
  ) u_b (.clk(clk), .rst_n(rst_n), .io(ib));

  s10_sum_tree_plus_const #(
    .SIZE(8), .NUM(3), .CONST(1), .TAG_W(4)
  ) u_c (.clk(clk), .rst_n(rst_n), .io(ic));

  task automatic check(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_sum(input int vals[$], input int cst,
                                     input int size, output bit sat);
    longint s = cst;
    foreach (vals[i]) s += vals[i];
    sat = 1'b0;
`ifdef S10_SUM_SAT_EN
    if (s > (longint'(1) << size) - 1) begin
      s = (longint'(1) << size) - 1;
      sat = 1'b1;
    end else if (s < -(longint'(1) << size)) begin
      s = -(longint'(1) << size);
      sat = 1'b1;
    end
`endif
    return s;
  endfunction

  function automatic int rnd_op(input int size);
    int v = int'($urandom_range(0, (1 << size) - 1));
    return v - ((v >= (1 << (size - 1))) ? (1 << size) : 0);
  endfunction

  task automatic a_one(input int v[4], input int tg, input string nm);
    int q[$];
    bit s;
    longint e;
    foreach (v[i]) q.push_back(v[i]);
    e = ref_sum(q, 1, 8, s);
    @(negedge clk);
    ia.out_ready = 1'b1;
    ia.in_valid  = 1'b1;
    ia.in_tag    = 4'(tg);
    for (int i = 0; i < 4; i++) ia.in_data[i*8 +: 8] = 8'(v[i]);
    #1 check({nm, "_rdy"}, ia.in_ready, 1);
    @(negedge clk);
    ia.in_valid = 1'b0;
    check({nm, "_early"}, ia.out_valid, 0);
    @(negedge clk);
    check({nm, "_vld"}, ia.out_valid, 1);
    check({nm, "_data"}, ia.out_data, e);
    check({nm, "_tag"}, ia.out_tag, tg);
    check({nm, "_sat"}, ia.out_sat, s);
  endtask

  initial begin
    int    pat[4] = '{1, 0, 0, 1};
    int    qd[$];
    int    qt[$];
    int    qs[$];
    int    ops[$];
    int    sent;
    int    got;
    int    cyc;
    bit    pend;
    bit    s;
    longint e;

    rst_n = 1'b0;
    ia.in_valid = 0; ia.in_data = '0; ia.in_tag = '0; ia.out_ready = 1;
    ib.in_valid = 0; ib.in_data = '0; ib.in_tag = '0; ib.out_ready = 1;
    ic.in_valid = 0; ic.in_data = '0; ic.in_tag = '0; ic.out_ready = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", ia.out_valid, 0);
    check("rst_rdy", ia.in_ready, 0);
    check("rst_data", ia.out_data, 0);
    check("rst_tag", ia.out_tag, 0);
    check("rst_sat", ia.out_sat, 0);
    check("rst_vld_b", ib.out_valid, 0);
    rst_n = 1'b1;
    #1 check("rdy_rise", ia.in_ready, 1);

    a_one('{1, 2, 3, 4}, 5, "basic");
    a_one('{-128, -128, -128, -128}, 6, "allmin");
    a_one('{127, 127, 127, 127}, 7, "allmax");
    a_one('{-1, 1, -100, 99}, 2, "mixed");

    // NUM=3: padded zero operand must not disturb the sum
    @(negedge clk);
    ic.in_valid = 1;
    ic.in_tag   = 4'd9;
    ic.in_data  = {8'd7, 8'd6, 8'd5};
    @(negedge clk);
    ic.in_valid = 0;
    @(negedge clk);
    check("pad_vld", ic.out_valid, 1);
    check("pad_data", ic.out_data, 19);
    check("pad_tag", ic.out_tag, 9);

    // backpressure on A: tags 0..7, out_ready 1,0,0,1 repeating
    qd = {}; qt = {}; qs = {};
    sent = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      ia.out_ready = pat[cyc % 4] != 0;
      ia.in_valid  = sent < 8;
      if (sent < 8) begin
        ops = {};
        for (int i = 0; i < 4; i++) begin
          ops.push_back(rnd_op(8));
          ia.in_data[i*8 +: 8] = 8'(ops[i]);
        end
        ia.in_tag = 4'(sent);
      end
      #1;
      check("bp_rdy", ia.in_ready,
            !(ia.out_valid && !ia.out_ready));
      if (ia.out_valid) begin
        if (qd.size() == 0) begin
          check("bp_spurious", ia.out_valid, 0);
        end else begin
          check("bp_data", ia.out_data, qd[0]);
          check("bp_tag", ia.out_tag, qt[0]);
          check("bp_sat", ia.out_sat, qs[0]);
          if (ia.out_ready) begin
            void'(qd.pop_front());
            void'(qt.pop_front());
            void'(qs.pop_front());
            got++;
          end
        end
      end
      if (ia.in_valid && ia.in_ready) begin
        e = ref_sum(ops, 1, 8, s);
        qd.push_back(int'(e));
        qt.push_back(sent);
        qs.push_back(int'(s));
        sent++;
      end
      cyc++;
    end
    ia.in_valid = 0;
    check("bp_count", got, 8);
    check("bp_left", qd.size(), 0);

    // reset with two beats in flight; neither may surface afterwards
    ia.out_ready = 1;
    @(negedge clk);
    ia.in_valid = 1; ia.in_tag = 4'd1; ia.in_data = {8'd10, 8'd10, 8'd10, 8'd10};
    @(negedge clk);
    ia.in_tag = 4'd2; ia.in_data = {8'd20, 8'd20, 8'd20, 8'd20};
    @(negedge clk);
    ia.in_valid = 0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_vld", ia.out_valid, 0);
    check("mrst_rdy", ia.in_ready, 0);
    check("mrst_data", ia.out_data, 0);
    check("mrst_tag", ia.out_tag, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mrst_quiet", ia.out_valid, 0);
    end
    a_one('{3, -7, 50, 12}, 3, "post_rst");

    // random stream on B with random backpressure and edge operands
    qd = {}; qt = {}; qs = {};
    sent = 0; got = 0; cyc = 0; pend = 0;
    while (got < 300 && cyc < 5000) begin
      @(negedge clk);
      ib.out_ready = $urandom_range(0, 3) != 0;
      if (!pend && sent < 300 && $urandom_range(0, 3) != 0) begin
        int mode = int'($urandom_range(0, 9));
        ops = {};
        for (int i = 0; i < 8; i++) begin
          ops.push_back(mode == 0 ? 2047 : mode == 1 ? -2048 : rnd_op(12));
          ib.in_data[i*12 +: 12] = 12'(ops[i]);
        end
        ib.in_tag = 4'(sent);
        pend = 1;
      end
      ib.in_valid = pend;
      #1;
      if (ib.out_valid) begin
        if (qd.size() == 0) begin
          check("rnd_spurious", ib.out_valid, 0);
        end else begin
          check("rnd_data", ib.out_data, qd[0]);
          check("rnd_tag", ib.out_tag, qt[0]);
          check("rnd_sat", ib.out_sat, qs[0]);
          if (ib.out_ready) begin
            void'(qd.pop_front());
            void'(qt.pop_front());
            void'(qs.pop_front());
            got++;
          end
        end
      end
      if (pend && ib.in_ready) begin
        e = ref_sum(ops, -5, 12, s);
        qd.push_back(int'(e));
        qt.push_back(sent % 16);
        qs.push_back(int'(s));
        sent++;
        pend = 0;
      end
      cyc++;
    end
    ib.in_valid = 0;
    check("rnd_count", got, 300);
    check("rnd_left", qd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/s10_sum_tree_plus_const.md
# s10_sum_tree_plus_const

Pipelined, parametrised signed adder tree. Each accepted beat sums NUM signed SIZE-bit operands plus a compile-time constant CONST. Each tree node is a 2-input adder; level-1 node 0 is a 3-input a+b+CONST adder built with the xor/majority carry-save formulation. Sits in the dot-product datapath after the multiplier array. Uses a valid/ready handshake on both sides.

## Interface
- SIZE, 12, operand width, signed two's complement
- NUM, 8, operand count, ≥2; need not be a power of two
- CONST, 1, signed constant added once per beat, must fit in SIZE bits
- TAG_W, 4, sideband tag width, carried alongside data
- Derived: LVL = clog2(NUM); OUT_W = SIZE + LVL + 1
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  NUM*SIZE  operand i at [i*SIZE +: SIZE]
- in_tag  in  TAG_W  sideband, returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  OUT_W  signed sum
- out_tag  out  TAG_W  tag of the beat in out_data
- out_sat  out  1  result was clamped; only active when saturation is compiled in

## Operation
- Operands are padded with zeros to 2^LVL.
- Level k (1..LVL) adds adjacent pairs from level k-1. Each level-k result is sign-extended to SIZE+k+1 bits and registered.
- CONST is injected exactly once, into level-1 node 0:
  - xor = a^b^CONST; maj = a&b | a&CONST | b&CONST
  - sum = sext(xor) + (sext(maj) << 1), computed at full width with no truncation.
- Each level has a valid bit and a tag register that travel with the data.
- Global enable en = !out_valid | out_ready. All levels advance together only when en=1.
- When en=0, every register holds its value.
- in_ready = en while rst_n=1; in_ready = 0 during reset.
- Bubbles are not collapsed: an invalid slot occupies its stage like a valid one.
- The final level register drives out_data, out_tag and out_valid directly. There is no output logic after it.
- Arithmetic is exact: OUT_W covers NUM·(−2^(SIZE−1)) + CONST through NUM·(2^(SIZE−1)−1) + CONST.

## Timing
- Latency is LVL cycles from an accepted beat to out_valid, provided out_ready stays high.
- Throughput is 1 beat/cycle when out_ready stays high.
- Reset (rst_n=0 at a clock edge) clears all valid bits, data registers and tag registers to 0.
  - Outputs after reset: out_valid=0, out_data=0, out_tag=0, out_sat=0, in_ready=0 while reset is asserted.
  - in_ready rises combinationally once rst_n=1.
- Reset mid-operation discards all in-flight beats. No partial result is ever emitted.
- Holding rule: while out_valid=1 and out_ready=0, out_data and out_tag are stable and no input is accepted.
- When in_valid=1, out_valid=1 and out_ready=1 in the same cycle, the output beat retires and the input beat is accepted in that cycle.
- NUM=2 gives LVL=1, i.e. a single registered stage.

## Configuration
- S10_SUM_SAT_EN defined:
  - The final level's result is clamped to the signed range of SIZE+1 bits, [−2^SIZE, 2^SIZE−1], then sign-extended to OUT_W.
  - out_sat=1 with the clamped beat. out_sat is registered in the final stage, so latency is unchanged.
- S10_SUM_SAT_EN undefined:
  - No clamp logic is built; out_sat is tied to 0.

## Test plan
- SIZE=8, NUM=4, CONST=1; in_data={4,3,2,1}, out_ready=1 → out_data=11 and out_tag equal to in_tag, exactly 2 cycles after acceptance.
- All four operands = −128 → out_data=−511. All four = 127 → 509 without macro; with S10_SUM_SAT_EN → 255 and out_sat=1.
- NUM=3, SIZE=8, CONST=1; operands 5,6,7 → 19; the padded zero operand has no effect.
- Back-to-back beats with tags 0..7 while out_ready toggles 1,0,0,1,… → every result in order, none lost or duplicated; in_ready=0 exactly on cycles where out_valid=1 and out_ready=0.
- rst_n=0 for one cycle while 2 beats are in flight → out_valid=0 the next cycle; only post-reset beats appear afterwards, with correct sums.
- Random signed operands at NUM=8, SIZE=12, CONST=−5 with random backpressure → each result matches a scoreboard exact sum.
